// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - 2-bit saturating-counter branch history table with mispredict statistics
//
// Purpose:
//   Predicts taken/not-taken for the instruction in IF from a direct-mapped
//   table of 2-bit saturating counters. The table is trained by the resolved
//   outcome of the branch in ID. Mispredictions are flagged combinationally
//   so pipeline control can flush and redirect in the same cycle. Saturating
//   counters track resolved branches and mispredictions.
//
// Ports:
//   Clk              in   rising-edge clock
//   Reset            in   asynchronous active-high reset
//   IfPC             in   PC of the instruction in IF
//   Prediction       out  predicted taken for IfPC (combinational table read)
//   IdPC             in   PC of the branch in ID
//   ResolveValid     in   ID holds a conditional branch to resolve
//   ResolveTaken     in   comparator outcome for that branch
//   ResolvePredicted in   prediction carried with the branch through IF/ID
//   Stall            in   ID held this cycle; blocks training and mispredict
//   ClearTable       in   synchronous re-initialisation of all entries
//   Mispredict       out  qualified resolution whose outcome differs from prediction
//   BranchCount      out  saturating count of qualified resolutions
//   MispredictCount  out  saturating count of mispredictions

module branch_predictor_bht #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [PC_WIDTH-1:0]  IfPC,
    output logic                 Prediction,
    input  logic [PC_WIDTH-1:0]  IdPC,
    input  logic                 ResolveValid,
    input  logic                 ResolveTaken,
    input  logic                 ResolvePredicted,
    input  logic                 Stall,
    input  logic                 ClearTable,
    output logic                 Mispredict,
    output logic [CNT_WIDTH-1:0] BranchCount,
    output logic [CNT_WIDTH-1:0] MispredictCount
);

    localparam int NUM_ENTRIES = 1 << INDEX_BITS;

    // Weak not-taken: one taken outcome flips the prediction.
    localparam logic [1:0] ENTRY_INIT = 2'b01;

    logic [1:0]            bht [NUM_ENTRIES];
    logic [INDEX_BITS-1:0] if_index;
    logic [INDEX_BITS-1:0] id_index;
    logic                  resolve_fire;
    logic [1:0]            cur_entry;
    logic [1:0]            next_entry;

    // Word-aligned PCs: bits [1:0] and everything above the index are ignored,
    // so PCs differing only there alias onto the same entry.
    assign if_index = IfPC[INDEX_BITS+1:2];
    assign id_index = IdPC[INDEX_BITS+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{IfPC[PC_WIDTH-1:INDEX_BITS+2], IfPC[1:0],
                              IdPC[PC_WIDTH-1:INDEX_BITS+2], IdPC[1:0]};

    // Read-before-write: a same-cycle update to this index is seen next cycle.
    assign Prediction = bht[if_index][1];

    assign resolve_fire = ResolveValid & ~Stall;
    assign Mispredict   = resolve_fire & (ResolveTaken ^ ResolvePredicted);

    assign cur_entry = bht[id_index];

    always_comb begin
        next_entry = cur_entry;
        if (ResolveTaken) begin
            if (cur_entry != 2'b11) begin
                next_entry = cur_entry + 2'b01;
            end
        end else begin
            if (cur_entry != 2'b00) begin
                next_entry = cur_entry - 2'b01;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                bht[i] <= ENTRY_INIT;
            end
        end else if (ClearTable) begin
            // Clear wins over a concurrent training update.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                bht[i] <= ENTRY_INIT;
            end
        end else if (resolve_fire) begin
            bht[id_index] <= next_entry;
        end
    end

    // Statistics still count a resolution that coincides with ClearTable.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            BranchCount     <= '0;
            MispredictCount <= '0;
        end else if (resolve_fire) begin
            if (BranchCount != {CNT_WIDTH{1'b1}}) begin
                BranchCount <= BranchCount + 1'b1;
            end
            if (Mispredict && (MispredictCount != {CNT_WIDTH{1'b1}})) begin
                MispredictCount <= MispredictCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - scoreboard bench for branch_predictor_bht

module tb_branch_predictor_bht;

    logic        Clk;
    logic        Reset;
    logic [31:0] IfPC;
    logic [31:0] IdPC;
    logic        ResolveValid;
    logic        ResolveTaken;
    logic        ResolvePredicted;
    logic        Stall;
    logic        ClearTable;
    logic        Prediction;
    logic        Mispredict;
    logic [15:0] BranchCount;
    logic [15:0] MispredictCount;
    logic        pred2;
    logic        misp2;
    logic [1:0]  bc2;
    logic [1:0]  mc2;

    branch_predictor_bht #(.PC_WIDTH(32), .INDEX_BITS(4), .CNT_WIDTH(16)) u_dut (
        .Clk(Clk), .Reset(Reset), .IfPC(IfPC), .Prediction(Prediction),
        .IdPC(IdPC), .ResolveValid(ResolveValid), .ResolveTaken(ResolveTaken),
        .ResolvePredicted(ResolvePredicted), .Stall(Stall), .ClearTable(ClearTable),
        .Mispredict(Mispredict), .BranchCount(BranchCount), .MispredictCount(MispredictCount)
    );

    branch_predictor_bht #(.PC_WIDTH(32), .INDEX_BITS(4), .CNT_WIDTH(2)) u_dut_sat (
        .Clk(Clk), .Reset(Reset), .IfPC(IfPC), .Prediction(pred2),
        .IdPC(IdPC), .ResolveValid(ResolveValid), .ResolveTaken(ResolveTaken),
        .ResolvePredicted(ResolvePredicted), .Stall(Stall), .ClearTable(ClearTable),
        .Mispredict(misp2), .BranchCount(bc2), .MispredictCount(mc2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic        pred;
        logic        misp;
        logic [15:0] bc;
        logic [15:0] mc;
        logic [1:0]  bc2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   stim_done = 1'b0;

    task automatic check(input string name, input string field,
                         input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, req);
        end
    endtask

    // Monitor: DUT outputs are stable mid-cycle; each pending expectation
    // belongs to the cycle in which it was issued.
    initial begin
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, "Prediction",      {15'd0, Prediction}, {15'd0, e.pred});
                check(e.name, "Mispredict",      {15'd0, Mispredict}, {15'd0, e.misp});
                check(e.name, "BranchCount",     BranchCount,         e.bc);
                check(e.name, "MispredictCount", MispredictCount,     e.mc);
                check(e.name, "BranchCount_w2",  {14'd0, bc2},        {14'd0, e.bc2});
            end
        end
    end

    // Drives one cycle of inputs (called at posedge+1) and queues the
    // expected outputs for that cycle.
    task automatic step(input string name, input logic [31:0] ifpc, input logic [31:0] idpc,
                        input logic rv, input logic rt, input logic rp, input logic st,
                        input logic clr, input logic e_pred, input logic e_misp,
                        input logic [15:0] e_bc, input logic [15:0] e_mc, input logic [1:0] e_bc2);
        exp_t e;
        IfPC = ifpc; IdPC = idpc; ResolveValid = rv; ResolveTaken = rt;
        ResolvePredicted = rp; Stall = st; ClearTable = clr;
        e.name = name; e.pred = e_pred; e.misp = e_misp;
        e.bc = e_bc; e.mc = e_mc; e.bc2 = e_bc2;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; IfPC = '0; IdPC = '0; ResolveValid = 0; ResolveTaken = 0;
        ResolvePredicted = 0; Stall = 0; ClearTable = 0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Reset state across all 16 indices
        for (int i = 0; i < 16; i++) begin
            step("reset_sweep", 32'(i * 4), 32'h0, 0, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0, 2'd0);
        end

        // Train 0x40 toward taken
        step("train_t_mp",  32'h40, 32'h40, 1, 1, 0, 0, 0, 0, 1, 16'd0, 16'd0, 2'd0);
        step("train_t_ok",  32'h40, 32'h40, 1, 1, 1, 0, 0, 1, 0, 16'd1, 16'd1, 2'd1);
        // Four not-taken resolutions: 11 -> 10 -> 01 -> 00 -> 00
        step("nt1",         32'h40, 32'h40, 1, 0, 1, 0, 0, 1, 1, 16'd2, 16'd1, 2'd2);
        step("nt2",         32'h40, 32'h40, 1, 0, 1, 0, 0, 1, 1, 16'd3, 16'd2, 2'd3);
        step("nt3",         32'h40, 32'h40, 1, 0, 0, 0, 0, 0, 0, 16'd4, 16'd3, 2'd3);
        step("nt4",         32'h40, 32'h40, 1, 0, 0, 0, 0, 0, 0, 16'd5, 16'd3, 2'd3);
        step("idx0_read",   32'h40, 32'h0,  0, 0, 0, 0, 0, 0, 0, 16'd6, 16'd3, 2'd3);
        step("alias_0x80",  32'h80, 32'h0,  0, 0, 0, 0, 0, 0, 0, 16'd6, 16'd3, 2'd3);

        // Stalled resolution: no pulse, no training, then one pulse on release
        for (int i = 0; i < 3; i++) begin
            step("stall",   32'h48, 32'h48, 1, 1, 0, 1, 0, 0, 0, 16'd6, 16'd3, 2'd3);
        end
        step("stall_rel",   32'h48, 32'h48, 1, 1, 0, 0, 0, 0, 1, 16'd6, 16'd3, 2'd3);
        step("stall_after", 32'h48, 32'h0,  0, 0, 0, 0, 0, 1, 0, 16'd7, 16'd4, 2'd3);

        // Same-cycle read/write of one index
        step("rbw_same",    32'h44, 32'h44, 1, 1, 0, 0, 0, 0, 1, 16'd7, 16'd4, 2'd3);
        step("rbw_next",    32'h44, 32'h0,  0, 0, 0, 0, 0, 1, 0, 16'd8, 16'd5, 2'd3);

        // ClearTable wins over a concurrent taken update; stats still count it
        step("clear_upd",   32'h48, 32'h44, 1, 1, 1, 0, 1, 1, 0, 16'd8, 16'd5, 2'd3);
        step("clear_44",    32'h44, 32'h0,  0, 0, 0, 0, 0, 0, 0, 16'd9, 16'd5, 2'd3);
        step("clear_48",    32'h48, 32'h0,  0, 0, 0, 0, 0, 0, 0, 16'd9, 16'd5, 2'd3);
        step("pre_rst",     32'h44, 32'h44, 1, 1, 0, 0, 0, 0, 1, 16'd9, 16'd5, 2'd3);

        // Reset asserted mid-cycle with an update pending
        Reset = 1'b1;
        step("mid_reset",   32'h44, 32'h44, 1, 1, 1, 0, 0, 0, 0, 16'd0, 16'd0, 2'd0);
        Reset = 1'b0;
        step("post_rst",    32'h44, 32'h44, 1, 1, 0, 0, 0, 0, 1, 16'd0, 16'd0, 2'd0);
        step("post_rst_rd", 32'h44, 32'h0,  0, 0, 0, 0, 0, 1, 0, 16'd1, 16'd1, 2'd1);

        stim_done = 1'b1;
    end

    initial begin
        int budget;
        wait (stim_done);
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge Clk);
            budget++;
        end
        checks++;
        if (exp_q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Fetch-side counterpart to the ID-stage branch comparator: a 2-bit saturating-counter branch history table (BHT).
- Predicts taken/not-taken for the instruction in IF.
- Is later trained by the comparator's resolved outcome in ID.
- Flags mispredictions so pipeline control can flush IF/ID and redirect the PC; keeps saturating branch/mispredict statistics.

Parameters:
- PC_WIDTH, 32, width of program counter inputs.
- INDEX_BITS, 4, BHT has 2^INDEX_BITS entries; index = PC[INDEX_BITS+1:2].
- CNT_WIDTH, 16, width of statistics counters.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- IfPC  input  PC_WIDTH  PC of instruction currently in IF.
- Prediction  output  1  predicted taken for IfPC (combinational table read).
- IdPC  input  PC_WIDTH  PC of branch instruction currently in ID.
- ResolveValid  input  1  ID holds a conditional branch (BEQ/BNE with compare enabled).
- ResolveTaken  input  1  comparator result for that branch.
- ResolvePredicted  input  1  Prediction value carried with the branch through IF/ID.
- Stall  input  1  ID stage held this cycle; suppresses training and mispredict.
- ClearTable  input  1  synchronous re-initialisation of all BHT entries.
- Mispredict  output  1  ResolveValid & !Stall & (ResolveTaken != ResolvePredicted).
- BranchCount  output  CNT_WIDTH  resolved branches since reset, saturating.
- MispredictCount  output  CNT_WIDTH  mispredictions since reset, saturating.

Behaviour:
- Entry encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Prediction = entry[IfPC index][1].
- Reset (async, immediate): all entries = 01, BranchCount = 0, MispredictCount = 0.
  - Prediction therefore reads 0 for every PC during and after reset.
  - Mispredict is purely combinational from inputs and has no reset dependence.
- Training: on a rising edge with ResolveValid=1 and Stall=0, entry at IdPC index updates.
  - Taken: +1, saturating at 11.
  - Not taken: -1, saturating at 00.
  - Exactly one entry changes per cycle.
- Latency: updated entry is visible on Prediction the cycle after the training edge.
- Same-cycle read/write of the same index: Prediction shows the pre-update value (read-before-write, no bypass).
- Mispredict: combinational, same cycle as resolution. Asserted at most once per branch because Stall gates it; a stalled branch is resolved when Stall drops.
- Statistics, on the same qualified edge as training:
  - BranchCount +1.
  - MispredictCount +1 if Mispredict.
  - Both hold at all-ones (no wrap).
- ClearTable=1 at an edge:
  - All entries become 01.
  - Has priority over training in the same cycle; the concurrent update is dropped.
  - Statistics still count that resolution.
- Aliasing: PCs sharing index bits share an entry; no tag check.
- Low PC bits [1:0] and bits above INDEX_BITS+1 are ignored.
- ResolveTaken/ResolvePredicted are don't-care when ResolveValid=0.
- Reset asserted mid-operation: table and counters return to reset values immediately; a training update in flight is lost.

Test Plan:
- Reset, then sweep IfPC 0x00..0x3C -> Prediction=0 for all; BranchCount=0; MispredictCount=0.
- IdPC=0x40, ResolveValid=1, Taken=1, Predicted=0 -> Mispredict=1 same cycle; next cycle IfPC=0x40 gives Prediction=1. Repeat with Predicted=1 -> Mispredict=0, entry 11. Result: BranchCount=2, MispredictCount=1.
- From entry 11 at 0x40, four not-taken resolutions -> entry 10, 01, 00, 00; Prediction goes 1, 0, 0, 0. IfPC=0x80 (aliases index 0) also reads 0.
- ResolveValid=1, Taken=1, Predicted=0, Stall=1 for 3 cycles -> Mispredict=0, no entry or counter change. Stall drops -> single Mispredict pulse, counters +1.
- IfPC=IdPC=0x44 with a training update in the same cycle -> Prediction shows old value that cycle, new value next. ClearTable together with a taken update -> entry 01, BranchCount still +1.
- CNT_WIDTH=2, six resolutions -> BranchCount stops at 3. Assert Reset mid-sequence -> all outputs immediately return to reset values.
